// File: rtl/elpis_io_pkg.sv
// Shared definitions for the Elpis I/O mailbox.
//   DATA_W      : default I/O word width.
//   io_state_t  : input-path FSM states (IDLE, WAIT_HOST, DELIVER).
//   tgl_edge()  : detects a PicoRV toggle flip against a stored reference bit.
package elpis_io_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HOST = 2'd1,
        DELIVER   = 2'd2
    } io_state_t;

    // PicoRV signals "new event" by flipping a level, not by pulsing.
    // An event is pending whenever the live level differs from the last
    // level we consumed.
    function automatic logic tgl_edge(input logic cur, input logic seen);
        return cur ^ seen;
    endfunction

endpackage

// File: rtl/elpis_io_fifo.sv
// Synchronous FIFO for core output words.
//   clk, rst   : clock, synchronous active-low reset (clears pointers/count).
//   push       : write push_data; ignored when full.
//   pop        : drop head word; ignored when empty.
//   head       : word at the read pointer, 0 when empty.
//   count      : occupancy 0..DEPTH.
//   full       : count == DEPTH.
module elpis_io_fifo
    import elpis_io_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    // Pointers carry one extra bit so they wrap modulo 2*DEPTH; only the
    // low IDX_W bits address the memory.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count = count_q;

endmodule

// File: rtl/elpis_io_mailbox.sv
// Elpis I/O mailbox between the Elpis core and chip_controller / PicoRV.
//   Output path: core words (valid/ready) -> FIFO -> host_out_data/valid/count;
//                PicoRV pops the head by flipping host_out_ack_tgl.
//   Input path : core raises core_in_req; host_in_pending shows it is waiting;
//                PicoRV flips host_in_tgl with host_in_data; the core then sees a
//                one-cycle core_in_valid with core_in_data.
//   clk, rst   : clock, synchronous active-low reset.
// Handshake: a core word transfers on a rising clk edge where
// core_out_valid && core_out_ready; core_out_ready depends on registered state only.
module elpis_io_mailbox
    import elpis_io_pkg::*;
#(
    parameter int DATA_W = elpis_io_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              core_out_ready,
    input  logic              core_in_req,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_valid,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    output logic [CNT_W-1:0]  host_out_count,
    input  logic              host_out_ack_tgl,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_tgl,
    output logic              host_in_pending
);

    io_state_t         state_q, state_d;
    logic              in_q, in_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              fifo_full;

    // ---------------- output path ----------------
    // A flip seen while the FIFO is empty is consumed here (ack_q follows
    // every cycle) and the FIFO ignores the pop, so it cannot pop a later word.
    assign ack_d          = host_out_ack_tgl;
    assign core_out_ready = rst && !fifo_full;
    assign host_out_valid = (host_out_count != '0);

    elpis_io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (core_out_valid && core_out_ready),
        .push_data (core_out_data),
        .pop       (tgl_edge(host_out_ack_tgl, ack_q)),
        .head      (host_out_data),
        .count     (host_out_count),
        .full      (fifo_full)
    );

    // ---------------- input path FSM ----------------
    // Outside WAIT_HOST the toggle reference tracks the live level, so flips
    // that happen before or just after a request can never satisfy it.
    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        in_data_d = in_data_q;
        case (state_q)
            IDLE: begin
                in_d = host_in_tgl;
                if (core_in_req) state_d = WAIT_HOST;
            end
            WAIT_HOST: begin
                if (!core_in_req) begin
                    state_d = IDLE;
                end else if (tgl_edge(host_in_tgl, in_q)) begin
                    in_data_d = host_in_data;
                    in_d      = host_in_tgl;
                    state_d   = DELIVER;
                end
            end
            DELIVER: begin
                in_d    = host_in_tgl;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            in_q      <= host_in_tgl;
            ack_q     <= host_out_ack_tgl;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            ack_q     <= ack_d;
            in_data_q <= in_data_d;
        end
    end

    assign core_in_valid   = (state_q == DELIVER);
    assign host_in_pending = (state_q == WAIT_HOST);
    assign core_in_data    = in_data_q;

endmodule

// File: tb/tb_elpis_io_mailbox.sv
// Testbench for elpis_io_mailbox: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_elpis_io_mailbox;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          core_out_valid;
    logic [DW-1:0] core_out_data;
    logic          core_out_ready;
    logic          core_in_req;
    logic [DW-1:0] core_in_data;
    logic          core_in_valid;
    logic [DW-1:0] host_out_data;
    logic          host_out_valid;
    logic [CW-1:0] host_out_count;
    logic          host_out_ack_tgl;
    logic [DW-1:0] host_in_data;
    logic          host_in_tgl;
    logic          host_in_pending;

    always #5 clk = ~clk;

    elpis_io_mailbox #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .core_out_valid   (core_out_valid),
        .core_out_data    (core_out_data),
        .core_out_ready   (core_out_ready),
        .core_in_req      (core_in_req),
        .core_in_data     (core_in_data),
        .core_in_valid    (core_in_valid),
        .host_out_data    (host_out_data),
        .host_out_valid   (host_out_valid),
        .host_out_count   (host_out_count),
        .host_out_ack_tgl (host_out_ack_tgl),
        .host_in_data     (host_in_data),
        .host_in_tgl      (host_in_tgl),
        .host_in_pending  (host_in_pending)
    );

    // ---------------- scoreboard state ----------------
    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];      // words the FIFO should hold, oldest first
    logic [DW-1:0] in_exp_q[$];   // words the core should be handed next
    logic          ack_seen = 1'b0;
    logic          tgl_seen = 1'b0;
    logic          m_wait    = 1'b0;
    logic          m_deliver = 1'b0;
    logic [DW-1:0] m_word    = '0;
    logic          acc_prev  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor + reference model ----------------
    // At each falling edge: compare DUT outputs with the model, then advance
    // the model by the effect of the inputs the next rising edge will see.
    always @(negedge clk) begin
        logic do_push, do_pop;
        chk("out_count", DW'(host_out_count), DW'(exp_q.size()));
        chk("out_valid", DW'(host_out_valid), DW'(exp_q.size() != 0));
        chk("out_data", host_out_data, (exp_q.size() != 0) ? exp_q[0] : '0);
        chk("out_ready", DW'(core_out_ready), DW'(rst && exp_q.size() < DEPTH));
        chk("in_pending", DW'(host_in_pending), DW'(m_wait));
        chk("in_valid", DW'(core_in_valid), DW'(m_deliver));
        chk("in_hold", core_in_data, m_word);
        if (core_in_valid === 1'b1) begin
            if (in_exp_q.size() == 0) chk("in_unexpected", DW'(1), DW'(0));
            else chk("in_data", core_in_data, in_exp_q.pop_front());
        end

        if (!rst) begin
            exp_q.delete();
            in_exp_q.delete();
            m_wait    = 1'b0;
            m_deliver = 1'b0;
            m_word    = '0;
            tgl_seen  = host_in_tgl;
        end else begin
            // Output FIFO: pop and push both judged on the occupancy before the edge.
            do_pop  = (host_out_ack_tgl != ack_seen) && (exp_q.size() != 0);
            do_push = core_out_valid && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(core_out_data);
            // Input path: a waiting request is served by a flip newer than the
            // last level seen; otherwise the seen level simply follows the input.
            if (m_deliver) begin
                m_deliver = 1'b0;
                tgl_seen  = host_in_tgl;
            end else if (m_wait) begin
                if (!core_in_req) begin
                    m_wait = 1'b0;
                end else if (host_in_tgl != tgl_seen) begin
                    m_wait    = 1'b0;
                    m_deliver = 1'b1;
                    m_word    = host_in_data;
                    tgl_seen  = host_in_tgl;
                    in_exp_q.push_back(host_in_data);
                end
            end else begin
                tgl_seen = host_in_tgl;
                if (core_in_req) m_wait = 1'b1;
            end
        end
        ack_seen = host_out_ack_tgl;
    end

    // ---------------- driver tasks ----------------
    // One cycle: acc_prev reports whether a core word transferred at the edge.
    task automatic tick();
        @(negedge clk);
        acc_prev = core_out_valid && core_out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input int flip_after);
        logic done = 1'b0;
        core_out_valid = 1'b1;
        core_out_data  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            if (i == flip_after) host_out_ack_tgl = ~host_out_ack_tgl;
            tick();
            done = acc_prev;
        end
        chk("push_accept", DW'(done), DW'(1));
        core_out_valid = 1'b0;
    endtask

    task automatic flip_ack();
        host_out_ack_tgl = ~host_out_ack_tgl;
        tick();
    endtask

    task automatic flip_in(input logic [DW-1:0] w);
        host_in_data = w;
        host_in_tgl  = ~host_in_tgl;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; core_out_valid = 1'b0; core_out_data = '0; core_in_req = 1'b0;
        host_out_ack_tgl = 1'b0; host_in_data = '0; host_in_tgl = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single word through the FIFO, then popped.
        push_word(32'hA5A5_0001, -1);
        tick();
        flip_ack();
        tick();

        // Fill to DEPTH; the 5th word waits until a pop frees a slot.
        for (int i = 1; i <= DEPTH; i++) push_word(DW'(i), -1);
        push_word(DW'(DEPTH + 1), 3);
        repeat (DEPTH) flip_ack();
        tick();

        // Flips while empty are discarded.
        flip_ack();
        flip_ack();
        push_word(32'h0000_1234, -1);
        repeat (3) tick();
        flip_ack();

        // Input word delivered on request.
        core_in_req = 1'b1;
        repeat (2) tick();
        flip_in(32'hDEAD_BEEF);
        core_in_req = 1'b0;
        repeat (3) tick();

        // Flip while idle must not satisfy a later request.
        flip_in(32'h1111_2222);
        core_in_req = 1'b1;
        repeat (4) tick();
        flip_in(32'h3333_4444);
        core_in_req = 1'b0;
        repeat (3) tick();

        // Reset with a partly full FIFO and a pending request.
        for (int i = 0; i < 3; i++) push_word($urandom, -1);
        core_in_req = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        core_in_req = 1'b0;
        tick();

        // Random traffic on both paths.
        for (int c = 0; c < 800; c++) begin
            if (acc_prev || !core_out_valid) begin
                core_out_valid = ($urandom_range(0, 1) == 1);
                core_out_data  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) host_out_ack_tgl = ~host_out_ack_tgl;
            if (!core_in_req) core_in_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 9) == 0) core_in_req = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                host_in_data = $urandom;
                host_in_tgl  = ~host_in_tgl;
            end
            rst = ($urandom_range(0, 150) != 0);
            tick();
        end

        rst = 1'b1; core_out_valid = 1'b0; core_in_req = 1'b0;
        repeat (4) tick();
        chk("in_left", DW'(in_exp_q.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
